// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, ALU control and FSM state types for the ALU sequencer
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    ADC  = 4'd1,
    SUB  = 4'd2,
    SBC  = 4'd3,
    AND  = 4'd4,
    OR   = 4'd5,
    XOR  = 4'd6,
    NOTA = 4'd7,
    LSR  = 4'd8,
    ASR  = 4'd9,
    CMP  = 4'd10
  } op_e;

  typedef struct packed {
    logic ci;
    logic nb;
    logic ic;
    logic na;
    logic xo;
    logic no;
    logic sr;
    logic ss;
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == LSR) || (code == ASR);
  endfunction

  function automatic logic is_arith(input logic [3:0] code);
    return (code == ADD) || (code == ADC) || (code == SUB) || (code == SBC) || (code == CMP);
  endfunction

  function automatic logic is_legal(input logic [3:0] code);
    return code <= CMP;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - op request, ALU drive and result bundle of the sequencer
interface alu_sequencer_if #(
  parameter int BYTES = 2
);
  localparam int WIDTH = 8 * BYTES;

  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [7:0]       alu_ctrl;
  logic [7:0]       alu_out;
  logic             alu_cf;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_cf;
  logic             res_zf;
  logic             res_err;

  modport master (
    input  op_valid, op_code, op_a, op_b, alu_out, alu_cf, res_ready,
    output op_ready, alu_a, alu_b, alu_ctrl, res_valid, res_data, res_cf, res_zf, res_err
  );

  modport slave (
    output op_valid, op_code, op_a, op_b, alu_out, alu_cf, res_ready,
    input  op_ready, alu_a, alu_b, alu_ctrl, res_valid, res_data, res_cf, res_zf, res_err
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - maps opcode and byte position to the ALU control word
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [3:0] op_code_i,
  input  logic       first_i,
  input  logic       top_i,
  input  logic       carry_i,
  input  logic       flag_cf_i,
  output alu_ctrl_t  ctrl_o,
  output logic       b_zero_o
);

  always_comb begin
    ctrl_o    = '0;
    ctrl_o.ic = 1'b1;
    b_zero_o  = 1'b0;
    case (op_code_i)
      ADD: begin
        ctrl_o.ic = 1'b0;
        ctrl_o.ci = first_i ? 1'b0 : carry_i;
      end
      ADC: begin
        ctrl_o.ic = 1'b0;
        ctrl_o.ci = first_i ? flag_cf_i : carry_i;
      end
      SUB, CMP: begin
        ctrl_o.ic = 1'b0;
        ctrl_o.nb = 1'b1;
        ctrl_o.ci = first_i ? 1'b1 : carry_i;
      end
      SBC: begin
        ctrl_o.ic = 1'b0;
        ctrl_o.nb = 1'b1;
        ctrl_o.ci = first_i ? flag_cf_i : carry_i;
      end
      AND: begin
        ctrl_o.na = 1'b1;
        ctrl_o.nb = 1'b1;
        ctrl_o.xo = 1'b1;
        ctrl_o.no = 1'b1;
      end
      OR:  ctrl_o.xo = 1'b1;
      XOR: ctrl_o.ic = 1'b1;
      NOTA: begin
        ctrl_o.na = 1'b1;
        b_zero_o  = 1'b1;
      end
      LSR: begin
        ctrl_o.sr = 1'b1;
        b_zero_o  = 1'b1;
      end
      ASR: begin
        ctrl_o.sr = 1'b1;
        ctrl_o.ss = top_i;
        b_zero_o  = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - runs one WIDTH-bit op through the external 8-bit ALU a byte per cycle
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int BYTES = 2
) (
  input logic              clk,
  input logic              rst,
  alu_sequencer_if.master  bus
);

  localparam int CW = $clog2(BYTES + 1);
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             code_q, code_d;
  logic [BYTES-1:0][7:0]  a_q, a_d;
  logic [BYTES-1:0][7:0]  b_q, b_d;
  logic [BYTES-1:0][7:0]  res_q, res_d;
  logic                   carry_q, carry_d;
  logic                   shin_q, shin_d;
  logic                   cf_q, cf_d;
  logic                   zf_q, zf_d;
  logic                   err_q, err_d;

  logic                   exec;
  logic                   shift;
  logic [IW-1:0]          idx;
  logic                   first;
  logic                   top;
  alu_ctrl_t              ctrl;
  logic                   b_zero;
  logic [7:0]             res_byte;

  // Shifts walk from the top byte down so each byte can borrow bit0 of the one above.
  assign exec  = (state_q == EXEC);
  assign shift = is_shift(code_q);
  assign idx   = shift ? IW'(LAST - cnt_q) : IW'(cnt_q);
  assign first = (cnt_q == '0);
  assign top   = (idx == IW'(BYTES - 1));

  alu_ctrl_decode u_decode (
    .op_code_i (code_q),
    .first_i   (first),
    .top_i     (top),
    .carry_i   (carry_q),
    .flag_cf_i (cf_q),
    .ctrl_o    (ctrl),
    .b_zero_o  (b_zero)
  );

  assign bus.alu_ctrl  = exec ? ctrl : '0;
  assign bus.alu_a     = exec ? a_q[idx] : '0;
  assign bus.alu_b     = (exec && !b_zero) ? b_q[idx] : '0;
  assign bus.op_ready  = (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_q;
  assign bus.res_cf    = cf_q;
  assign bus.res_zf    = zf_q;
  assign bus.res_err   = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    carry_d  = carry_q;
    shin_d   = shin_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    err_d    = err_q;
    res_byte = (shift && !top) ? {shin_q, bus.alu_out[6:0]} : bus.alu_out;

    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          code_d = bus.op_code;
          a_d    = bus.op_a;
          b_d    = bus.op_b;
          cnt_d  = '0;
          err_d  = 1'b0;
          if (is_legal(bus.op_code)) begin
            state_d = EXEC;
          end else begin
            state_d = DONE;
            res_d   = bus.op_a;
            err_d   = 1'b1;
          end
        end
      end
      EXEC: begin
        res_d[idx] = res_byte;
        carry_d    = bus.alu_cf;
        shin_d     = a_q[idx][0];
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          zf_d    = (res_d == '0);
          if (is_arith(code_q)) begin
            cf_d = bus.alu_cf;
          end else if (shift) begin
            cf_d = a_q[0][0];
          end
          // CMP reports flags of the subtraction but hands A back unchanged.
          if (code_q == CMP) begin
            res_d = a_q;
          end
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      shin_q  <= 1'b0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      shin_q  <= shin_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - bench for alu_sequencer with a behavioural 8-bit ALU attached
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  logic m_cf = 1'b0;
  logic m_zf = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer_if #(.BYTES(2)) bus ();

  alu_sequencer #(.BYTES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ctrl = {ci,nb,ic,na,xo,no,sr,ss}
  logic [7:0] xa, xb, xl;
  logic [8:0] sum;
  always_comb begin
    xa  = bus.alu_ctrl[4] ? ~bus.alu_a : bus.alu_a;
    xb  = bus.alu_ctrl[6] ? ~bus.alu_b : bus.alu_b;
    sum = {1'b0, xa} + {1'b0, xb} + {8'd0, bus.alu_ctrl[7]};
    xl  = bus.alu_ctrl[3] ? (xa | xb) : (xa ^ xb);
    bus.alu_out = 8'd0;
    bus.alu_cf  = 1'b0;
    if (bus.alu_ctrl[1]) begin
      bus.alu_out = {bus.alu_ctrl[0] & bus.alu_a[7], bus.alu_a[7:1]};
      bus.alu_cf  = bus.alu_a[0];
    end else if (!bus.alu_ctrl[5]) begin
      bus.alu_out = bus.alu_ctrl[2] ? ~sum[7:0] : sum[7:0];
      bus.alu_cf  = sum[8];
    end else begin
      bus.alu_out = bus.alu_ctrl[2] ? ~xl : xl;
    end
  end

  typedef struct {
    logic [3:0]  code;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ed;
    logic        ecf;
    logic        ezf;
    logic        eerr;
    int          hold;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ref_op(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b,
                        input logic cf_in, input logic zf_in,
                        output logic [15:0] d, output logic cf, output logic zf, output logic err);
    int s;
    err = 1'b0;
    cf  = cf_in;
    zf  = zf_in;
    d   = a;
    case (code)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd10: begin
        case (code)
          4'd0:    s = int'(a) + int'(b);
          4'd1:    s = int'(a) + int'(b) + int'(cf_in);
          4'd3:    s = int'(a) - int'(b) - 1 + int'(cf_in) + 65536;
          default: s = int'(a) - int'(b) + 65536;
        endcase
        d  = s[15:0];
        cf = (s >= 65536);
        zf = (d == 16'd0);
        if (code == 4'd10) d = a;
      end
      4'd4: begin d = a & b; zf = (d == 16'd0); end
      4'd5: begin d = a | b; zf = (d == 16'd0); end
      4'd6: begin d = a ^ b; zf = (d == 16'd0); end
      4'd7: begin d = ~a;    zf = (d == 16'd0); end
      4'd8: begin d = a >> 1; cf = a[0]; zf = (d == 16'd0); end
      4'd9: begin d = 16'($signed(a) >>> 1); cf = a[0]; zf = (d == 16'd0); end
      default: err = 1'b1;
    endcase
  endtask

  task automatic apply(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ed, input logic ecf, input logic ezf, input logic eerr,
                       input int hold, input string tag);
    int lat;
    bit got;
    @(negedge clk);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus.op_ready) got = 1;
      else @(negedge clk);
    end
    check({tag, " op_ready"}, 32'(got), 32'd1);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op_a     = 16'($urandom);
    bus.op_b     = 16'($urandom);
    lat = 0;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus.res_valid) got = 1;
    end
    check({tag, " latency"}, 32'(lat), eerr ? 32'd1 : 32'd3);
    check({tag, " data"}, 32'(bus.res_data), 32'(ed));
    check({tag, " cf"}, 32'(bus.res_cf), 32'(ecf));
    check({tag, " zf"}, 32'(bus.res_zf), 32'(ezf));
    check({tag, " err"}, 32'(bus.res_err), 32'(eerr));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " held valid"}, 32'(bus.res_valid), 32'd1);
      check({tag, " held op_ready"}, 32'(bus.op_ready), 32'd0);
      check({tag, " held data"}, 32'(bus.res_data), 32'(ed));
      check({tag, " held flags"}, 32'({bus.res_cf, bus.res_zf, bus.res_err}), 32'({ecf, ezf, eerr}));
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check({tag, " valid drop"}, 32'(bus.res_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " op_ready"}, 32'(bus.op_ready), 32'd1);
    check({tag, " res_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, " alu drive"}, 32'({bus.alu_ctrl, bus.alu_a, bus.alu_b}), 32'd0);
    check({tag, " res_data"}, 32'(bus.res_data), 32'd0);
    check({tag, " flags"}, 32'({bus.res_cf, bus.res_zf, bus.res_err}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic        cf, zf, err, first_valid;
    logic [3:0]  code;
    logic [15:0] a, b;

    bus.op_valid  = 1'b0;
    bus.op_code   = 4'd0;
    bus.op_a      = 16'd0;
    bus.op_b      = 16'd0;
    bus.res_ready = 1'b0;

    tbl[0]  = '{4'd0,  16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 0};
    tbl[2]  = '{4'd1,  16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 0};
    tbl[3]  = '{4'd2,  16'h0100, 16'h0001, 16'h00FF, 1'b1, 1'b0, 1'b0, 0};
    tbl[4]  = '{4'd10, 16'h1234, 16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0, 0};
    tbl[5]  = '{4'd9,  16'h8003, 16'h0000, 16'hC001, 1'b1, 1'b0, 1'b0, 0};
    tbl[6]  = '{4'd8,  16'h8003, 16'hFFFF, 16'h4001, 1'b1, 1'b0, 1'b0, 0};
    tbl[7]  = '{4'd4,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b1, 1'b0, 1'b0, 5};
    tbl[8]  = '{4'd15, 16'hABCD, 16'h1111, 16'hABCD, 1'b1, 1'b0, 1'b1, 5};
    tbl[9]  = '{4'd3,  16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0};
    tbl[10] = '{4'd3,  16'h0010, 16'h0001, 16'h000E, 1'b1, 1'b0, 1'b0, 0};
    tbl[11] = '{4'd7,  16'hFFFF, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0, 0};
    tbl[12] = '{4'd6,  16'h5A5A, 16'h5A5A, 16'h0000, 1'b1, 1'b1, 1'b0, 0};
    tbl[13] = '{4'd5,  16'h1200, 16'h0034, 16'h1234, 1'b1, 1'b0, 1'b0, 0};
    tbl[14] = '{4'd1,  16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 0};
    tbl[15] = '{4'd11, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 0};
    tbl[16] = '{4'd9,  16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 0};
    tbl[17] = '{4'd8,  16'h0100, 16'h0000, 16'h0080, 1'b0, 1'b0, 1'b0, 0};
    tbl[18] = '{4'd12, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].code, tbl[i].a, tbl[i].b, tbl[i].ed, tbl[i].ecf, tbl[i].ezf,
            tbl[i].eerr, tbl[i].hold, $sformatf("tbl%0d", i));
    end

    // Abort an op during its first EXEC cycle.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 4'd0;
    bus.op_a     = 16'h4444;
    bus.op_b     = 16'h1111;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    #2;
    check("mid-op alu active", 32'(bus.alu_ctrl == 8'd0), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    first_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.res_valid) first_valid = 1'b1;
    end
    check("no result after abort", 32'(first_valid), 32'd0);
    apply(4'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 0, "post-reset add");
    m_cf = 1'b0;
    m_zf = 1'b0;

    for (int k = 0; k < 150; k++) begin
      code = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      a    = 16'($urandom);
      b    = ($urandom_range(0, 5) == 0) ? a : 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'h0001 << $urandom_range(0, 15);
      ref_op(code, a, b, m_cf, m_zf, d, cf, zf, err);
      apply(code, a, b, d, cf, zf, err, $urandom_range(0, 2),
            $sformatf("rnd%0d op%0d a=%h b=%h", k, code, a, b));
      m_cf = cf;
      m_zf = zf;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
